// File: rtl/mandel_iter_pipe.sv
// Four-slot pipelined Mandelbrot iteration datapath, z <= z^2 + c in Q4.28.
// Operands come from the slot multiplexer. This block returns the updated z per slot,
// tracks the iteration count and escape state of each slot, and hands the four counts
// downstream through a valid/ready handshake.
module mandel_iter_pipe #(
  parameter int FRAC     = 28,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  ld,
  input  logic                  in_valid,
  input  logic [1:0]            in_slot,
  input  logic [31:0]           a_in,
  input  logic [31:0]           b_in,
  input  logic [31:0]           c_re0,
  input  logic [31:0]           c_re1,
  input  logic [31:0]           c_re2,
  input  logic [31:0]           c_re3,
  input  logic [31:0]           c_im0,
  input  logic [31:0]           c_im1,
  input  logic [31:0]           c_im2,
  input  logic [31:0]           c_im3,
  output logic [31:0]           a1,
  output logic [31:0]           a2,
  output logic [31:0]           a3,
  output logic [31:0]           a4,
  output logic [31:0]           b1,
  output logic [31:0]           b2,
  output logic [31:0]           b3,
  output logic [31:0]           b4,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [4*ITER_W-1:0]   iter_counts
);

  // |z|^2 must be strictly above 4.0; the product domain carries 2*FRAC fraction bits
  localparam logic signed [64:0] ESC_LIMIT = 65'sd4 <<< (2 * FRAC);
  localparam logic [ITER_W-1:0]  MAX_CNT   = ITER_W'(MAX_ITER);

  logic               s1_valid;
  logic [1:0]         s1_slot;
  logic signed [31:0] s1_a, s1_b;

  logic               s2_valid;
  logic [1:0]         s2_slot;
  logic signed [63:0] s2_aa, s2_bb, s2_ab;

  logic               s3_valid;
  logic [1:0]         s3_slot;
  logic [33:0]        s3_re, s3_im;
  logic               s3_esc;

  logic [31:0]        za [4];
  logic [31:0]        zb [4];
  logic [ITER_W-1:0]  cnt [4];
  logic [3:0]         done;

  logic [31:0]        c_re_sel, c_im_sel;
  logic signed [64:0] mag, diff;
  logic [33:0]        re_calc, im_calc;
  logic               re_ovf, im_ovf, wb_esc;
  logic [31:0]        re_sat, im_sat;
  logic [ITER_W-1:0]  cnt_inc;

  assign a1 = za[0];
  assign a2 = za[1];
  assign a3 = za[2];
  assign a4 = za[3];
  assign b1 = zb[0];
  assign b2 = zb[1];
  assign b3 = zb[2];
  assign b4 = zb[3];

  // pick the constant c for the slot currently in the combine stage
  always_comb begin
    c_re_sel = c_re0;
    c_im_sel = c_im0;
    case (s2_slot)
      2'd1: begin c_re_sel = c_re1; c_im_sel = c_im1; end
      2'd2: begin c_re_sel = c_re2; c_im_sel = c_im2; end
      2'd3: begin c_re_sel = c_re3; c_im_sel = c_im3; end
      default: begin c_re_sel = c_re0; c_im_sel = c_im0; end
    endcase
  end

  // the 65-bit sums cannot overflow; the new z is kept to 34 bits so the last stage can see overflow
  assign mag     = 65'(s2_aa) + 65'(s2_bb);
  assign diff    = 65'(s2_aa) - 65'(s2_bb);
  assign re_calc = 34'(diff >>> FRAC) + {{2{c_re_sel[31]}}, c_re_sel};
  assign im_calc = 34'(s2_ab >>> (FRAC - 1)) + {{2{c_im_sel[31]}}, c_im_sel};

  // results outside signed 32 bits saturate and count as escaped
  assign re_ovf  = (s3_re[33:31] != 3'b000) && (s3_re[33:31] != 3'b111);
  assign im_ovf  = (s3_im[33:31] != 3'b000) && (s3_im[33:31] != 3'b111);
  assign re_sat  = re_ovf ? (s3_re[33] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s3_re[31:0];
  assign im_sat  = im_ovf ? (s3_im[33] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s3_im[31:0];
  assign wb_esc  = s3_esc | re_ovf | im_ovf;
  assign cnt_inc = cnt[s3_slot] + ITER_W'(1);

  // three register stages: input capture, squares/cross product, combine with c and escape test
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      s1_valid <= 1'b0;
      s1_slot  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_slot  <= '0;
      s2_aa    <= '0;
      s2_bb    <= '0;
      s2_ab    <= '0;
      s3_valid <= 1'b0;
      s3_slot  <= '0;
      s3_re    <= '0;
      s3_im    <= '0;
      s3_esc   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_slot  <= in_slot;
      s1_a     <= a_in;
      s1_b     <= b_in;
      s2_valid <= s1_valid;
      s2_slot  <= s1_slot;
      s2_aa    <= 64'(s1_a) * 64'(s1_a);
      s2_bb    <= 64'(s1_b) * 64'(s1_b);
      s2_ab    <= 64'(s1_a) * 64'(s1_b);
      s3_valid <= s2_valid;
      s3_slot  <= s2_slot;
      s3_re    <= re_calc;
      s3_im    <= im_calc;
      s3_esc   <= (mag > ESC_LIMIT);
    end
  end

  // fourth stage: write back per-slot z and count, track group state and the result handshake
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      for (int i = 0; i < 4; i++) begin
        za[i]  <= '0;
        zb[i]  <= '0;
        cnt[i] <= '0;
      end
      done         <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      iter_counts  <= '0;
    end else begin
      if (ld && !busy) begin
        for (int i = 0; i < 4; i++) begin
          za[i]  <= '0;
          zb[i]  <= '0;
          cnt[i] <= '0;
        end
        done <= '0;
        busy <= 1'b1;
      end else if (s3_valid && !done[s3_slot]) begin
        if (wb_esc) begin
          done[s3_slot] <= 1'b1;
        end else begin
          za[s3_slot]  <= re_sat;
          zb[s3_slot]  <= im_sat;
          cnt[s3_slot] <= cnt_inc;
          if (cnt_inc == MAX_CNT) begin
            done[s3_slot] <= 1'b1;
          end
        end
      end
      if (busy && (done == 4'hF) && !result_valid) begin
        result_valid <= 1'b1;
        iter_counts  <= {cnt[3], cnt[2], cnt[1], cnt[0]};
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mandel_iter_pipe.sv
// Self-checking bench for mandel_iter_pipe. The bench plays the slot multiplexer and
// keeps a reference model of each slot's orbit, computed with plain 64-bit arithmetic.
module tb_mandel_iter_pipe;

  localparam int FRAC = 28;
  localparam int MAXI = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        aclk, aresetn, ld, in_valid, result_ready, busy, result_valid;
  logic [1:0]  in_slot;
  logic [31:0] a_in, b_in, iter_counts;
  logic [31:0] cre [4];
  logic [31:0] cim [4];
  logic [31:0] out_a [4];
  logic [31:0] out_b [4];

  logic [31:0] m_a [4];
  logic [31:0] m_b [4];
  logic [7:0]  m_cnt [4];
  logic [3:0]  m_done;
  logic [31:0] seen;

  int checks = 0;
  int errors = 0;

  mandel_iter_pipe #(.FRAC(FRAC), .ITER_W(8), .MAX_ITER(MAXI)) dut (
    .aclk(aclk), .aresetn(aresetn), .ld(ld), .in_valid(in_valid), .in_slot(in_slot),
    .a_in(a_in), .b_in(b_in),
    .c_re0(cre[0]), .c_re1(cre[1]), .c_re2(cre[2]), .c_re3(cre[3]),
    .c_im0(cim[0]), .c_im1(cim[1]), .c_im2(cim[2]), .c_im3(cim[3]),
    .a1(out_a[0]), .a2(out_a[1]), .a3(out_a[2]), .a4(out_a[3]),
    .b1(out_b[0]), .b2(out_b[1]), .b3(out_b[2]), .b4(out_b[3]),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .iter_counts(iter_counts)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [31:0] a,
                               input logic [31:0] b);
    in_valid = v;
    in_slot  = s;
    a_in     = a;
    b_in     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_a[i]   = '0;
      m_b[i]   = '0;
      m_cnt[i] = '0;
    end
    m_done = '0;
  endtask

  // One iteration of z^2 + c for slot s from operand (a, b), following the slot rules
  task automatic model_step(input int s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, aa, bb, ab, re, im;
    longint unsigned mag;
    bit esc;
    if (m_done[s]) return;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    aa  = sa * sa;
    bb  = sb * sb;
    ab  = sa * sb;
    mag = longint'(aa) + longint'(bb);
    esc = (mag > (64'd1 << (2 * FRAC + 2)));
    re  = ((aa - bb) >>> FRAC) + longint'($signed(cre[s]));
    im  = (ab >>> (FRAC - 1)) + longint'($signed(cim[s]));
    if (re > MAXV || re < MINV || im > MAXV || im < MINV) esc = 1'b1;
    if (esc) begin
      m_done[s] = 1'b1;
    end else begin
      m_a[s]   = re[31:0];
      m_b[s]   = im[31:0];
      m_cnt[s] = m_cnt[s] + 8'd1;
      if (m_cnt[s] == 8'(MAXI)) m_done[s] = 1'b1;
    end
  endtask

  task automatic issue_raw(input int s, input logic [31:0] a, input logic [31:0] b);
    model_step(s, a, b);
    applyStimulus(1'b1, 2'(s), a, b);
  endtask

  task automatic start_group();
    ld = 1'b1;
    tick();
    ld = 1'b0;
    model_clear();
    checkOutput("busy_after_ld", busy, 1'b1);
  endtask

  // Round-robin multiplexer: reissue each slot's current z until every slot is finished
  task automatic run_group(input bit bubbles, input int first);
    int s;
    s = first;
    while (m_done != 4'hF) begin
      if (bubbles && $urandom_range(0, 3) == 0) applyStimulus(1'b0, 2'd0, 32'd0, 32'd0);
      issue_raw(s, m_a[s], m_b[s]);
      s = (s + 1) % 4;
    end
  endtask

  task automatic finish_group(input int hold, input bit early, input bit ld_pulse,
                              output logic [31:0] counts_seen);
    int n;
    logic [31:0] exp_counts;
    exp_counts = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
    result_ready = early;
    n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("result_valid_rise", result_valid, 1'b1);
    counts_seen = iter_counts;
    checkOutput("iter_counts", iter_counts, exp_counts);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("a%0d", i + 1), out_a[i], m_a[i]);
      checkOutput($sformatf("b%0d", i + 1), out_b[i], m_b[i]);
    end
    checkOutput("busy_pending", busy, 1'b1);
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        ld = ld_pulse;
        tick();
        ld = 1'b0;
        checkOutput("counts_hold", iter_counts, exp_counts);
        checkOutput("valid_hold", result_valid, 1'b1);
        checkOutput("busy_hold", busy, 1'b1);
      end
      result_ready = 1'b1;
    end
    tick();
    result_ready = 1'b0;
    checkOutput("valid_clear", result_valid, 1'b0);
    checkOutput("busy_clear", busy, 1'b0);
  endtask

  initial begin
    aresetn = 1'b1;
    ld = 1'b0;
    in_valid = 1'b0;
    in_slot = '0;
    a_in = '0;
    b_in = '0;
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cre[i] = '0;
      cim[i] = '0;
    end
    model_clear();
    repeat (2) tick();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_valid", result_valid, 1'b0);
    checkOutput("rst_counts", iter_counts, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rst_a%0d", i + 1), out_a[i], 32'd0);
      checkOutput($sformatf("rst_b%0d", i + 1), out_b[i], 32'd0);
    end
    aresetn = 1'b0;
    tick();

    $display("[TB] reset in the middle of a group");
    for (int i = 0; i < 4; i++) cre[i] = 32'h4000_0000;
    start_group();
    issue_raw(0, 32'd0, 32'd0);
    repeat (4) applyStimulus(1'b0, 2'd0, 32'd0, 32'd0);
    checkOutput("mid_a1_before", out_a[0], m_a[0]);
    issue_raw(1, 32'd0, 32'd0);
    issue_raw(2, 32'd0, 32'd0);
    issue_raw(3, 32'd0, 32'd0);
    aresetn = 1'b1;
    #1;
    checkOutput("mid_busy", busy, 1'b0);
    checkOutput("mid_a1", out_a[0], 32'd0);
    checkOutput("mid_valid", result_valid, 1'b0);
    #2;
    aresetn = 1'b0;
    repeat (6) applyStimulus(1'b0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mid_post_a%0d", i + 1), out_a[i], 32'd0);
      checkOutput($sformatf("mid_post_b%0d", i + 1), out_b[i], 32'd0);
    end

    $display("[TB] escape counts with c = 1.0 and 4.0");
    cre[0] = 32'h1000_0000;
    start_group();
    run_group(1'b0, 0);
    finish_group(0, 1'b1, 1'b0, seen);
    checkOutput("esc_counts_const", seen, 32'h0101_0103);
    checkOutput("esc_a1_const", out_a[0], 32'h5000_0000);

    $display("[TB] |z|^2 equal to 4.0 never escapes, handshake held off");
    cre[0] = 32'hE000_0000;
    start_group();
    run_group(1'b0, 0);
    finish_group(5, 1'b0, 1'b1, seen);
    checkOutput("bnd_counts_const", seen, 32'h0101_0110);
    checkOutput("bnd_a1_const", out_a[0], 32'h2000_0000);

    $display("[TB] overflow and saturation force escape");
    cre[0] = 32'h7000_0000;
    cre[1] = 32'h7000_0000;
    start_group();
    issue_raw(0, 32'h7FFF_FFFF, 32'd0);
    issue_raw(1, 32'h2000_0000, 32'd0);
    run_group(1'b0, 2);
    finish_group(2, 1'b0, 1'b0, seen);
    checkOutput("ovf_counts_const", seen, 32'h0101_0000);
    checkOutput("ovf_a1_const", out_a[0], 32'd0);
    checkOutput("ovf_a2_const", out_a[1], 32'd0);

    $display("[TB] four-cycle latency with interleaved slots");
    for (int i = 0; i < 4; i++) begin
      cre[i] = '0;
      cim[i] = '0;
    end
    start_group();
    issue_raw(0, 32'h0800_0000, 32'h0800_0000);
    issue_raw(1, 32'h0800_0000, 32'h0800_0000);
    issue_raw(2, 32'h0800_0000, 32'h0800_0000);
    checkOutput("lat_b1_early", out_b[0], 32'd0);
    issue_raw(3, 32'h0800_0000, 32'h0800_0000);
    checkOutput("lat_b1_on_time", out_b[0], 32'h0800_0000);
    checkOutput("lat_a1_on_time", out_a[0], 32'd0);
    checkOutput("lat_b2_early", out_b[1], 32'd0);
    issue_raw(0, 32'h0800_0000, 32'h0800_0000);
    checkOutput("lat_b2_on_time", out_b[1], 32'h0800_0000);
    run_group(1'b0, 1);
    finish_group(1, 1'b0, 1'b0, seen);

    $display("[TB] randomized groups");
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) begin
        cre[i] = 32'($urandom_range(0, 32'h3FFF_FFFF)) - 32'h2000_0000;
        cim[i] = 32'($urandom_range(0, 32'h3FFF_FFFF)) - 32'h2000_0000;
      end
      start_group();
      run_group(1'b1, 0);
      finish_group(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mandel_iter_pipe.md
Name: mandel_iter_pipe

Overview:
- Four-slot pipelined complex iteration datapath: z(n+1) = z(n)^2 + c in signed fixed point.
- Sits directly downstream of the slot multiplexer. Consumes the selected a0/b0 each cycle.
- Produces the per-slot feedback values a1..a4 / b1..b4 that the multiplexer re-issues.
- Tracks per-slot iteration counts and escape, and hands the four counts to the colour/write-back stage via valid/ready.

Parameters:
- FRAC, 28, fraction bits of the Q4.28 signed 32-bit format.
- ITER_W, 8, iteration counter width.
- MAX_ITER, 255, iteration limit per pixel; legal range 1 .. 2^ITER_W-1.

Ports:
- aclk  in  1  clock, rising edge.
- aresetn  in  1  reset, asynchronous, active-high; the port name follows codebase convention and does not indicate polarity.
- ld  in  1  start a new group of four pixels; accepted only when busy=0.
- in_valid  in  1  a_in/b_in/in_slot valid this cycle.
- in_slot  in  2  slot tag of the operand, 0..3.
- a_in, b_in  in  32  current z (real, imag), Q4.28.
- c_re0..c_re3, c_im0..c_im3  in  32 each  per-slot constant c; must stay stable while busy=1.
- a1..a4, b1..b4  out  32 each  latest z for slots 0..3; feeds the multiplexer.
- busy  out  1  group in progress or result pending.
- result_valid  out  1  the four counts are available.
- result_ready  in  1  consumer accepts the counts.
- iter_counts  out  4*ITER_W  slot3..slot0 counts, with slot0 in the LSBs.

Behaviour:
- Reset (async, aresetn=1): all pipeline valids=0; a1..a4 = b1..b4 = 0; all counts = 0; done[3:0] = 0; busy = 0; result_valid = 0; iter_counts = 0.
- Pipeline is 4 stages, latency exactly 4 cycles. There is no stall and one operand is accepted per cycle.
  - S1: register a_in, b_in, in_slot, in_valid.
  - S2: 64-bit signed products aa = a*a, bb = b*b, ab = a*b.
  - S3: escape test (aa+bb) > (4 << 2*FRAC), evaluated in 65 bits, i.e. strictly greater than |z|^2 = 4.0.
    - re = (aa-bb)>>>FRAC + c_re[slot].
    - im = (ab>>>(FRAC-1)) + c_im[slot].
    - Both are computed in 34 bits with arithmetic shift and truncation toward -inf.
  - S4: register the result. If re or im does not fit in signed 32 bits, saturate it to 0x7FFFFFFF or 0x80000000 and force escaped=1.
- Writeback, on an S4 valid for slot s with done[s]=0:
  - If escaped: done[s] <= 1. Count and a/b for slot s are unchanged.
  - Otherwise: a(s+1)/b(s+1) <= re/im and count[s] <= count[s]+1. If count[s]+1 == MAX_ITER, also set done[s] <= 1.
- If done[s]=1, any S4 result for slot s is discarded, so the held a/b and count freeze.
- ld with busy=0: counts <= 0, done <= 0, a1..a4/b1..b4 <= 0, busy <= 1 on the next edge. ld with busy=1 is ignored.
- Operands already in flight when ld is accepted are processed under the new group. The upstream multiplexer does not issue operands before ld.
- When done == 4'b1111 and result_valid=0:
  - result_valid <= 1 and iter_counts <= counts on the next edge.
  - iter_counts is held stable until the cycle where result_valid & result_ready.
  - After that cycle, result_valid <= 0 and busy <= 0.
- If result_ready is already high when result_valid rises, the handshake completes in that first cycle.
- Slot tags are independent: any order or interleave is legal, including back-to-back operands for the same slot.
- in_valid=0 produces bubbles. Bubbles never alter counts, done, or held a/b.

Test Plan:
- Reset mid-group (aresetn pulse while 3 operands are in flight) -> same cycle: busy=0, a1..a4=0, result_valid=0. No S4 writeback occurs afterwards.
- Slot0 c=(0x10000000, 0), iterate from z=0; other slots c=(0x40000000, 0):
  - Slot0 z sequence is 0, 1.0, 2.0, 5.0. The 5.0 step escapes, giving count0=3 and a1=0x50000000.
  - The other slots escape on their second issue: z=0 gives 4.0, then |z|^2=16, so count=1.
  - Expect result_valid with iter_counts = {8'd1, 8'd1, 8'd1, 8'd3}.
- Boundary |z|^2 = 4.0 exactly: c=(0xE0000000, 0) (-2.0), MAX_ITER=16.
  - z sequence is 0, -2.0, 2.0, 2.0, ... and never escapes.
  - Expect count=16, done set on the 16th writeback, a=0x20000000.
- Overflow: a_in=0x7FFFFFFF, b_in=0, c=(0x70000000, 0) -> escaped forced. Slot frozen, count unchanged, held a unchanged.
- Handshake: hold result_ready=0 for 5 cycles after result_valid.
  - iter_counts stays stable and busy=1 throughout; ld pulses in that window are ignored.
  - On the result_ready=1 cycle the transfer completes; result_valid=0 and busy=0 on the next edge.
- Latency and interleave: issue slots 0,1,2,3,0 on consecutive cycles with c=0, z=(0x08000000, 0x08000000).
  - Each writeback lands exactly 4 cycles after its input.
  - Slot0's result (0, 0x08000000) is written 4 cycles after each of its two issues.
